// File: rtl/dual_port_ram_be_if.sv
// Write/read/clear bus for dual_port_ram_be.
// The master drives requests; the slave (the RAM) drives readiness and read results.
interface dual_port_ram_be_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;

    logic              clr_req;
    logic              init_busy;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_be,
        output rd_valid, rd_addr,
        output clr_req,
        input  wr_ready, rd_ready, rd_data, rd_data_valid, init_busy
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_be,
        input  rd_valid, rd_addr,
        input  clr_req,
        output wr_ready, rd_ready, rd_data, rd_data_valid, init_busy
    );
endinterface

// File: rtl/dual_port_ram_be.sv
// Simple dual-port RAM with byte enables, valid/ready ports and a clear sequencer
// that zeroes the array after reset or on clr_req; read latency 1 or 2 cycles.
module dual_port_ram_be #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    dual_port_ram_be_if.slave   bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if ((DATA_W == 0) || (DATA_W % 8 != 0) || (DEPTH == 0) ||
        (64'(DEPTH) > (64'd1 << ADDR_W)) || (READ_LAT < 1) || (READ_LAT > 2)) begin : g_param_err
        $error("dual_port_ram_be: illegal parameters DATA_W=%0d DEPTH=%0d ADDR_W=%0d READ_LAT=%0d",
               DATA_W, DEPTH, ADDR_W, READ_LAT);
    end

    typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              busy_q;
    logic              ready_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_fire_c;
    logic              rd_fire_c;
    logic              wr_in_range_c;
    logic              rd_in_range_c;
    logic [DATA_W-1:0] rd_word_c;

    logic [DATA_W-1:0] rd_data_q;
    logic              rd_data_valid_q;

    // Clear sequencer: walks clr_cnt over the array, then opens both ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state   <= ST_IDLE;
                        clr_cnt <= '0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.wr_ready  = ready_q;
    assign bus.rd_ready  = ready_q;
    assign bus.init_busy = busy_q;

    assign wr_fire_c     = bus.wr_valid && ready_q;
    assign rd_fire_c     = bus.rd_valid && ready_q;
    assign wr_in_range_c = 32'(bus.wr_addr) < DEPTH;
    assign rd_in_range_c = 32'(bus.rd_addr) < DEPTH;

    // Out-of-range reads return zero rather than touching the array.
    assign rd_word_c = rd_in_range_c ? mem[IDX_W'(bus.rd_addr)] : '0;

    // Array has no reset; the sequencer owns the write port while clearing.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[IDX_W'(clr_cnt)] <= '0;
        end else if (wr_fire_c && wr_in_range_c) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (bus.wr_be[b]) begin
                    mem[IDX_W'(bus.wr_addr)][8*b +: 8] <= bus.wr_data[8*b +: 8];
                end
            end
        end
    end

    if (READ_LAT == 1) begin : g_lat1
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rd_data_q       <= '0;
                rd_data_valid_q <= 1'b0;
            end else begin
                rd_data_valid_q <= rd_fire_c;
                if (rd_fire_c) begin
                    rd_data_q <= rd_word_c;
                end
            end
        end
    end else begin : g_lat2
        logic [DATA_W-1:0] s1_data;
        logic              s1_valid;

        // Array output register, then the output stage.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s1_data         <= '0;
                s1_valid        <= 1'b0;
                rd_data_q       <= '0;
                rd_data_valid_q <= 1'b0;
            end else begin
                s1_valid        <= rd_fire_c;
                rd_data_valid_q <= s1_valid;
                if (rd_fire_c) begin
                    s1_data <= rd_word_c;
                end
                if (s1_valid) begin
                    rd_data_q <= s1_data;
                end
            end
        end
    end

    assign bus.rd_data       = rd_data_q;
    assign bus.rd_data_valid = rd_data_valid_q;
endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: two instances (8-bit/16-deep/lat 1 and 32-bit/12-deep/lat 2)
// driven by the same directed stimulus and checked every cycle against an array model.
module tb_dual_port_ram_be;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEP_A = 16;
    localparam int unsigned DEP_B = 12;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 2;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          wr_valid = 1'b0;
    logic          rd_valid = 1'b0;
    logic          clr_req  = 1'b0;
    logic [AW-1:0] wr_addr  = '0;
    logic [AW-1:0] rd_addr  = '0;
    logic [31:0]   wr_data  = '0;
    logic [3:0]    wr_be    = '0;

    always #5 clk = ~clk;

    dual_port_ram_be_if #(.ADDR_W(AW), .DATA_W(8))  bus_a ();
    dual_port_ram_be_if #(.ADDR_W(AW), .DATA_W(32)) bus_b ();

    assign bus_a.wr_valid = wr_valid;
    assign bus_a.wr_addr  = wr_addr;
    assign bus_a.wr_data  = wr_data[7:0];
    assign bus_a.wr_be    = wr_be[0:0];
    assign bus_a.rd_valid = rd_valid;
    assign bus_a.rd_addr  = rd_addr;
    assign bus_a.clr_req  = clr_req;

    assign bus_b.wr_valid = wr_valid;
    assign bus_b.wr_addr  = wr_addr;
    assign bus_b.wr_data  = wr_data;
    assign bus_b.wr_be    = wr_be;
    assign bus_b.rd_valid = rd_valid;
    assign bus_b.rd_addr  = rd_addr;
    assign bus_b.clr_req  = clr_req;

    dual_port_ram_be #(.ADDR_W(AW), .DEPTH(DEP_A), .DATA_W(8), .READ_LAT(LAT_A)) u_ram_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    dual_port_ram_be #(.ADDR_W(AW), .DEPTH(DEP_B), .DATA_W(32), .READ_LAT(LAT_B)) u_ram_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] d;
    } pend_t;

    logic [31:0] mdl_mem  [2][16];
    bit          mdl_busy [2];
    int          mdl_left [2];
    logic [31:0] mdl_rd   [2];
    bit          mdl_rv   [2];
    pend_t       pend [$];
    int          cyc = 0;

    logic [31:0] last_rd [2];
    int          rd_seen [2];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic int dep(int i);
        return (i == 0) ? int'(DEP_A) : int'(DEP_B);
    endfunction

    function automatic int lat(int i);
        return (i == 0) ? int'(LAT_A) : int'(LAT_B);
    endfunction

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst=%s cyc=%0d actual=%h expected=%h", nm, (i == 0) ? "a" : "b", cyc, act, exp);
        end
    endtask

    // Compare current outputs with the model, then advance the model across the next edge.
    task automatic model_cycle();
        logic [31:0] act_d [2];
        logic        act_v [2];
        logic        act_b [2];
        logic        act_w [2];
        logic        act_r [2];
        act_d[0] = 32'(bus_a.rd_data);  act_d[1] = bus_b.rd_data;
        act_v[0] = bus_a.rd_data_valid; act_v[1] = bus_b.rd_data_valid;
        act_b[0] = bus_a.init_busy;     act_b[1] = bus_b.init_busy;
        act_w[0] = bus_a.wr_ready;      act_w[1] = bus_b.wr_ready;
        act_r[0] = bus_a.rd_ready;      act_r[1] = bus_b.rd_ready;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                mdl_busy[i] = 1'b1;
                mdl_left[i] = dep(i);
                mdl_rd[i]   = '0;
                mdl_rv[i]   = 1'b0;
            end
            chk("init_busy", i, 32'(act_b[i]), 32'(mdl_busy[i]));
            chk("wr_ready", i, 32'(act_w[i]), 32'(!mdl_busy[i]));
            chk("rd_ready", i, 32'(act_r[i]), 32'(!mdl_busy[i]));
            chk("rd_data_valid", i, 32'(act_v[i]), 32'(mdl_rv[i]));
            chk("rd_data", i, act_d[i], mdl_rd[i]);
            if (act_v[i] === 1'b1) begin
                last_rd[i] = act_d[i];
                rd_seen[i]++;
            end
        end
        if (!rst) begin
            pend.delete();
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (mdl_busy[i]) begin
                    mdl_left[i]--;
                    if (mdl_left[i] == 0) begin
                        mdl_busy[i] = 1'b0;
                        for (int a = 0; a < 16; a++) mdl_mem[i][a] = '0;
                    end
                end else begin
                    if (rd_valid) begin
                        pend.push_back('{i, cyc + lat(i) - 1,
                                         (int'(rd_addr) < dep(i)) ? mdl_mem[i][rd_addr] : 32'h0});
                    end
                    if (wr_valid && int'(wr_addr) < dep(i)) begin
                        for (int b = 0; b < ((i == 0) ? 1 : 4); b++) begin
                            if (wr_be[b]) mdl_mem[i][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
                        end
                    end
                    if (clr_req) begin
                        mdl_busy[i] = 1'b1;
                        mdl_left[i] = dep(i);
                    end
                end
                mdl_rv[i] = 1'b0;
                for (int k = 0; k < pend.size(); k++) begin
                    if (pend[k].inst == i && pend[k].due == cyc) begin
                        mdl_rv[i] = 1'b1;
                        mdl_rd[i] = pend[k].d;
                        pend.delete(k);
                        break;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        clr_req  = 1'b0;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        idle_inputs();
    endtask

    // Issues one read (plus any write already set up) and pins the returned words to literals.
    task automatic read_lit(input logic [AW-1:0] a, input logic [31:0] exp_a, input logic [31:0] exp_b,
                            input string nm);
        int sa = rd_seen[0];
        int sb = rd_seen[1];
        int k  = 0;
        rd_valid = 1'b1; rd_addr = a;
        tick();
        idle_inputs();
        while ((rd_seen[0] == sa || rd_seen[1] == sb) && k < 6) begin
            tick();
            k++;
        end
        chk({nm, "_timeout"}, 0, 32'(k >= 6), 32'h0);
        chk(nm, 0, last_rd[0], exp_a);
        chk(nm, 1, last_rd[1], exp_b);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!(bus_a.wr_ready === 1'b1 && bus_b.wr_ready === 1'b1) && k < 64) begin
            tick();
            k++;
        end
        chk("ready_timeout", 0, 32'(k >= 64), 32'h0);
    endtask

    initial begin
        int sa;
        int sb;
        int k;
        rd_seen[0] = 0; rd_seen[1] = 0;
        last_rd[0] = '0; last_rd[1] = '0;

        // Reset held for 3 cycles, then the post-reset clear.
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (15) tick();
        chk("t1_busy_at_15", 0, 32'(bus_a.init_busy), 32'h1);
        tick();
        chk("t1_busy_at_16", 0, 32'(bus_a.init_busy), 32'h0);
        wait_ready();
        for (int a = 0; a < 16; a++) begin
            rd_valid = 1'b1; rd_addr = AW'(a);
            tick();
        end
        idle_inputs();
        repeat (3) tick();
        read_lit(4'd15, 32'h0, 32'h0, "t1_rd15");

        // Single-byte write then read back.
        write(4'd3, 32'h0000_00A5, 4'b0001);
        read_lit(4'd3, 32'hA5, 32'hA5, "t2_rd3");

        // Byte-enable merge on the wide instance.
        write(4'd2, 32'h1122_3344, 4'b1111);
        write(4'd2, 32'hAABB_CCDD, 4'b0101);
        read_lit(4'd2, 32'hDD, 32'h11BB_33DD, "t3_merge");

        // Same-address write/read in one cycle is read-first.
        read_lit(4'd7, 32'h0, 32'h0, "t4_pre");
        wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 32'h0000_005A; wr_be = 4'b0001;
        read_lit(4'd7, 32'h0, 32'h0, "t4_collide");
        read_lit(4'd7, 32'h5A, 32'h5A, "t4_after");

        // Fill, then clear with reads in flight; requests during the clear are ignored.
        for (int a = 0; a < 16; a++) write(AW'(a), 32'hFFFF_FFFF, 4'b1111);
        sa = rd_seen[0]; sb = rd_seen[1];
        rd_valid = 1'b1; rd_addr = 4'd1;
        tick();
        rd_addr = 4'd2; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 32'h7777_7777; wr_be = 4'b1111;
        rd_valid = 1'b1; rd_addr = 4'd0;
        repeat (8) tick();
        idle_inputs();
        chk("t5_drain_cnt", 0, 32'(rd_seen[0] - sa), 32'd2);
        chk("t5_drain_cnt", 1, 32'(rd_seen[1] - sb), 32'd2);
        chk("t5_drain_data", 0, last_rd[0], 32'hFF);
        chk("t5_drain_data", 1, last_rd[1], 32'hFFFF_FFFF);
        wait_ready();
        read_lit(4'd0, 32'h0, 32'h0, "t5_clr0");
        read_lit(4'd9, 32'h0, 32'h0, "t5_clr9");

        // Out-of-range address on the 12-deep instance.
        write(4'd13, 32'h1234_5678, 4'b1111);
        read_lit(4'd13, 32'h78, 32'h0, "t6_oor");

        // Reset mid-clear restarts a full clear.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk("t6_rst_rd_data", 0, 32'(bus_a.rd_data), 32'h0);
        chk("t6_rst_busy", 0, 32'(bus_a.init_busy), 32'h1);
        repeat (2) tick();
        rst = 1'b1;
        k = 0;
        while (bus_a.init_busy === 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk("t6_busy_len", 0, 32'(k), 32'd16);
        wait_ready();
        read_lit(4'd13, 32'h0, 32'h0, "t6_after13");
        read_lit(4'd3, 32'h0, 32'h0, "t6_after3");
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
